// File: rtl/relu_pool_pkg.sv
// rtl/relu_pool_pkg.sv - shared types, sizes and signed max helper for relu_pool
package relu_pool_pkg;

  localparam int ROW_MAX = 512;
  localparam int DW      = 32;

  typedef enum logic [1:0] {IDLE, EVEN, ODD, FLUSH} state_t;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_rowbuf.sv
// rtl/pool_rowbuf.sv - 1W1R synchronous row buffer holding the even-row horizontal maxima
module pool_rowbuf
  import relu_pool_pkg::*;
#(
  parameter int DEPTH = ROW_MAX,
  parameter int W     = DW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are deliberately unreset; every location is written before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/relu_pool.sv
// rtl/relu_pool.sv - 2x2 max-pool plus ReLU over a stream of two-pixel conv words
module relu_pool
  import relu_pool_pkg::*;
#(
  parameter int ROW_MAX = relu_pool_pkg::ROW_MAX,
  parameter int DW      = relu_pool_pkg::DW
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESETN,
  input  logic          start,
  input  logic [8:0]    row_words_m1,
  input  logic [8:0]    rows_m1,
  output logic          busy,
  output logic          done,
  input  logic [2*DW-1:0] S_AXIS_TDATA,
  input  logic          S_AXIS_TVALID,
  output logic          S_AXIS_TREADY,
  output logic [2*DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TVALID,
  input  logic          M_AXIS_TREADY,
  output logic          M_AXIS_TLAST
);

  localparam int AW = $clog2(ROW_MAX);

  state_t state;
  logic [8:0] col, row, words_m1, rows_lim;

  logic s_fire, last_col, out_free, s1_adv;
  logic s1_valid, s1_emit, s1_hi, s1_last;
  logic signed [DW-1:0] hmax, s1_hmax, rd_data, pooled, relu, pack_lo;

  assign out_free      = ~M_AXIS_TVALID | M_AXIS_TREADY;
  assign S_AXIS_TREADY = (state == EVEN) | ((state == ODD) & out_free);
  assign s_fire        = S_AXIS_TVALID & S_AXIS_TREADY;
  assign last_col      = (col == words_m1);
  assign hmax          = smax(S_AXIS_TDATA[DW-1:0], S_AXIS_TDATA[2*DW-1:DW]);
  assign pooled        = smax(rd_data, s1_hmax);
  assign relu          = pooled[DW-1] ? '0 : pooled;
  // A stalled stage-1 entry only ever occurs while input is blocked, so it is never overwritten.
  assign s1_adv        = s1_valid & (~s1_emit | out_free);

  pool_rowbuf #(.DEPTH(ROW_MAX), .W(DW), .AW(AW)) u_rowbuf (
    .clk   (AXIS_ACLK),
    .we    (s_fire & (state == EVEN)),
    .waddr (col[AW-1:0]),
    .wdata (hmax),
    .re    (s_fire & (state == ODD)),
    .raddr (col[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      words_m1      <= '0;
      rows_lim      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      s1_valid      <= 1'b0;
      s1_emit       <= 1'b0;
      s1_hi         <= 1'b0;
      s1_last       <= 1'b0;
      s1_hmax       <= '0;
      pack_lo       <= '0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
        M_AXIS_TLAST  <= 1'b0;
      end

      if (s1_adv) begin
        if (s1_emit) begin
          M_AXIS_TVALID <= 1'b1;
          M_AXIS_TLAST  <= s1_last;
          M_AXIS_TDATA  <= s1_hi ? {relu, pack_lo} : {{DW{1'b0}}, relu};
        end else begin
          pack_lo <= relu;
        end
      end

      // Emit on odd columns, or on a trailing even column when the row width is odd.
      if (s_fire && state == ODD) begin
        s1_valid <= 1'b1;
        s1_hmax  <= hmax;
        s1_hi    <= col[0];
        s1_emit  <= col[0] | (last_col & ~words_m1[0]);
        s1_last  <= last_col & (row == rows_lim);
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            words_m1 <= row_words_m1;
            rows_lim <= rows_m1;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
            state    <= EVEN;
          end
        end
        EVEN, ODD: begin
          if (s_fire) begin
            if (last_col) begin
              col <= '0;
              row <= row + 9'd1;
              if (row == rows_lim) state <= FLUSH;
              else state <= (state == EVEN) ? ODD : EVEN;
            end else begin
              col <= col + 9'd1;
            end
          end
        end
        FLUSH: begin
          if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_pool.sv
// tb/tb_relu_pool.sv - randomized scoreboard bench for relu_pool
module tb_relu_pool;

  logic        clk, rst_n, start;
  logic [8:0]  row_words_m1, rows_m1;
  logic        busy, done;
  logic [63:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;

  relu_pool dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .start         (start),
    .row_words_m1  (row_words_m1),
    .rows_m1       (rows_m1),
    .busy          (busy),
    .done          (done),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TLAST  (m_tlast)
  );

  int          nchk = 0, nfail = 0, beats = 0;
  logic [63:0] frame_data[$];
  logic [64:0] exp_q[$];
  logic [64:0] cur_exp;
  logic [63:0] last_out;
  bit          abort = 0, bp_rand = 0, bp_hold = 0, hold_s = 0, inject_start = 0, rand_valid = 0;
  bit          seen;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkw(input int even_px, input int odd_px);
    return {odd_px, even_px};
  endfunction

  function automatic int rnd();
    return $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
  endfunction

  task automatic gen(input int n, input int mode);
    case (mode)
      0: for (int i = 0; i < n; i++) frame_data.push_back(mkw(rnd(), rnd()));
      1: for (int i = 0; i < n; i++)
           frame_data.push_back(mkw(-int'($urandom_range(1, 1000)), -int'($urandom_range(1, 1000))));
      2: begin
        frame_data.push_back(mkw(1, 5));
        frame_data.push_back(mkw(-3, 2));
        frame_data.push_back(mkw(4, 0));
        frame_data.push_back(mkw(7, -9));
      end
      default: begin
        frame_data.push_back({32'h7FFFFFFF, 32'h80000000});
        frame_data.push_back({32'h80000000, 32'h7FFFFFFF});
      end
    endcase
  endtask

  // Reference: each pooled pixel is the ReLU of the max over its 2x2 window of input pixels.
  task automatic build_model(input int w, input int r);
    int vals[$];
    int px[4];
    int m, hi;
    logic [63:0] a, b;
    for (int k = 0; k < r / 2; k++) begin
      vals.delete();
      for (int c = 0; c < w; c++) begin
        a = frame_data[2 * k * w + c];
        b = frame_data[(2 * k + 1) * w + c];
        px[0] = a[31:0]; px[1] = a[63:32]; px[2] = b[31:0]; px[3] = b[63:32];
        m = px[0];
        for (int q = 1; q < 4; q++) if (px[q] > m) m = px[q];
        vals.push_back(m < 0 ? 0 : m);
      end
      for (int j = 0; j < w; j += 2) begin
        hi = (j + 1 < w) ? vals[j + 1] : 0;
        exp_q.push_back({(k == r / 2 - 1) && (j + 2 >= w), hi, vals[j]});
      end
    end
  endtask

  initial begin
    m_tready = 1;
    forever begin
      @(posedge clk);
      hold_s = bp_hold;
      #1;
      m_tready = hold_s ? 1'b0 : (bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_tlast, m_tdata}, 65'h0);
        end else begin
          cur_exp = exp_q.pop_front();
          check("beat", {m_tlast, m_tdata}, cur_exp);
        end
        last_out = m_tdata;
        beats++;
      end
    end
  end

  task automatic feed(input int n);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < n && !abort && guard < 20000) begin
      @(posedge clk); #1;
      s_tvalid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_tdata  = frame_data[i];
      start    = inject_start && (i == 2);
      if (start) row_words_m1 = 9'd0;
      @(negedge clk);
      if (s_tvalid && s_tready) i++;
      guard++;
    end
    @(posedge clk); #1;
    s_tvalid = 0;
    start = 0;
    if (!abort) check("feed_count", i, n);
  endtask

  task automatic run_frame(input int w, input int r, input int mode, input bit rv, input bit bp,
                           input bit inj, input bit use_pin, input logic [64:0] pin);
    int  nbeats;
    bit  got;
    frame_data.delete();
    gen(w * r, mode);
    build_model(w, r);
    if (use_pin) check("model_pin", exp_q[0], pin);
    nbeats = (r / 2) * ((w + 1) / 2);
    rand_valid = rv; bp_rand = bp; inject_start = inj; beats = 0;
    @(posedge clk); #1;
    row_words_m1 = 9'(w - 1);
    rows_m1 = 9'(r - 1);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("busy_run", busy, 1);
    feed(w * r);
    got = 0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check("done_pulse", got, 1);
    check("busy_idle", busy, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("beat_count", beats, nbeats);
    check("drained", exp_q.size(), 0);
    if (use_pin) check("dut_pin", last_out, pin[63:0]);
    bp_rand = 0;
    inject_start = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
  endtask

  initial begin
    rst_n = 0; start = 0; s_tvalid = 0; s_tdata = 0;
    row_words_m1 = 0; rows_m1 = 0;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    run_frame(2, 2, 2, 0, 0, 0, 1, {1'b1, 32'd7, 32'd5});
    run_frame(2, 2, 1, 1, 0, 0, 1, {1'b1, 64'd0});
    run_frame(3, 2, 0, 1, 1, 0, 0, '0);
    run_frame(1, 2, 3, 0, 0, 0, 1, {1'b1, 32'd0, 32'h7FFFFFFF});

    fork
      run_frame(8, 2, 0, 0, 0, 0, 0, '0);
      begin
        seen = 0;
        for (int t = 0; t < 500 && !seen; t++) begin
          @(negedge clk);
          if (m_tvalid) seen = 1;
        end
        check("bp_valid_seen", seen, 1);
        bp_hold = 1;
        repeat (4) @(negedge clk);
        check("bp_s_tready", s_tready, 0);
        check("bp_m_tvalid", m_tvalid, 1);
        @(negedge clk);
        bp_hold = 0;
      end
    join

    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(1, 9), 2 * $urandom_range(1, 3), 0, 1, 1, f == 3, 0, '0);

    frame_data.delete();
    gen(16, 0);
    build_model(4, 4);
    rand_valid = 0; abort = 0;
    @(posedge clk); #1;
    row_words_m1 = 9'd3; rows_m1 = 9'd3; start = 1;
    @(posedge clk); #1;
    start = 0;
    fork
      feed(16);
      begin
        seen = 0;
        for (int t = 0; t < 500 && !seen; t++) begin
          @(negedge clk);
          if (m_tvalid) seen = 1;
        end
        check("rst_valid_seen", seen, 1);
        @(posedge clk); #1;
        rst_n = 0;
        abort = 1;
        #1;
        check_zero_outputs("midrst");
      end
    join
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    abort = 0;
    run_frame(4, 4, 0, 1, 1, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
